// File: rtl/hand_display_pkg.sv
// Shared card codes, 7-segment patterns, blink FSM states and value helpers
// for the baccarat hand register/display.
package hand_display_pkg;

    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    // Active-low segments, bit6 = g down to bit0 = a.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_ACE   = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_TEN   = 7'b1000000;
    localparam logic [6:0] SEG_JACK  = 7'b1100001;
    localparam logic [6:0] SEG_QUEEN = 7'b0011000;
    localparam logic [6:0] SEG_KING  = 7'b0001001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2
    } blink_state_t;

    // Baccarat value: ace counts one, pips count face, tens/courts/empty zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= CARD_ACE && code <= 4'd9) begin
            return code;
        end
        return 4'd0;
    endfunction

    // The score digit reuses the ten pattern for zero and a plain one for one.
    function automatic logic [6:0] score_digit(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_TEN;
            4'd1:    return SEG_ONE;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hand_display_card_seg_decode.sv
// Card code to active-low 7-segment pattern; empty and unused codes go blank.
module card_seg_decode
    import hand_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            CARD_ACE:   seg_o = SEG_ACE;
            4'd2:       seg_o = SEG_2;
            4'd3:       seg_o = SEG_3;
            4'd4:       seg_o = SEG_4;
            4'd5:       seg_o = SEG_5;
            4'd6:       seg_o = SEG_6;
            4'd7:       seg_o = SEG_7;
            4'd8:       seg_o = SEG_8;
            4'd9:       seg_o = SEG_9;
            CARD_TEN:   seg_o = SEG_TEN;
            CARD_JACK:  seg_o = SEG_JACK;
            CARD_QUEEN: seg_o = SEG_QUEEN;
            CARD_KING:  seg_o = SEG_KING;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hand_display.sv
// One baccarat hand: card slot registers, per-slot digits, registered score
// and a blink sequencer that flashes the most recently dealt slot.
module hand_display
    import hand_display_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int BLINK_HALF = 2,
    parameter int BLINK_REPS = 3,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    input  logic                   clear,
    input  logic                   load_en,
    input  logic [SW-1:0]          load_slot,
    input  logic [3:0]             load_card,
    input  logic                   blink_en,
    output logic [4*NUM_SLOTS-1:0] cards_out,
    output logic [7*NUM_SLOTS-1:0] seg7_out,
    output logic [3:0]             score,
    output logic [6:0]             score_seg,
    output logic                   busy
);

    localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int RW = (BLINK_REPS > 1) ? $clog2(BLINK_REPS) : 1;
    localparam logic [HW-1:0] HALF_LOAD = HW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] REP_LOAD  = RW'(BLINK_REPS - 1);

    logic [3:0]   slots_q [NUM_SLOTS];
    logic [3:0]   slots_d [NUM_SLOTS];
    logic [3:0]   score_q;
    logic [3:0]   score_d;
    logic [3:0]   storeCode;
    logic         validSlot;
    logic         blinkLoad;
    blink_state_t state_q;
    logic [SW-1:0] blinkSlot_q;
    logic [HW-1:0] halfCnt_q;
    logic [RW-1:0] repCnt_q;

    assign validSlot = int'(load_slot) < NUM_SLOTS;
    assign blinkLoad = load_en && blink_en && validSlot;
    assign storeCode = (load_card >= CARD_ACE && load_card <= CARD_KING) ? load_card : CARD_EMPTY;

    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clear) begin
                slots_d[i] = CARD_EMPTY;
            end else if (load_en && validSlot && load_slot == SW'(i)) begin
                slots_d[i] = storeCode;
            end
        end
    end

    // Running mod-10 sum keeps the adder narrow for any slot count.
    always_comb begin
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            acc = acc + {1'b0, card_value(slots_q[i])};
            if (acc >= 5'd10) begin
                acc = acc - 5'd10;
            end
        end
        score_d = acc[3:0];
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= CARD_EMPTY;
            end
            score_q <= '0;
        end else begin
            slots_q <= slots_d;
            score_q <= score_d;
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            blinkSlot_q <= '0;
            halfCnt_q   <= '0;
            repCnt_q    <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else if (blinkLoad) begin
            state_q     <= ST_OFF;
            blinkSlot_q <= load_slot;
            halfCnt_q   <= HALF_LOAD;
            repCnt_q    <= REP_LOAD;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (halfCnt_q == '0) begin
                        state_q   <= ST_ON;
                        halfCnt_q <= HALF_LOAD;
                    end else begin
                        halfCnt_q <= halfCnt_q - HW'(1);
                    end
                end
                ST_ON: begin
                    if (halfCnt_q == '0) begin
                        if (repCnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            repCnt_q  <= repCnt_q - RW'(1);
                            state_q   <= ST_OFF;
                            halfCnt_q <= HALF_LOAD;
                        end
                    end else begin
                        halfCnt_q <= halfCnt_q - HW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : gSlot
        logic [6:0] segRaw;

        card_seg_decode uDecode (
            .code_i (slots_q[i]),
            .seg_o  (segRaw)
        );

        assign cards_out[4*i +: 4] = slots_q[i];
        assign seg7_out[7*i +: 7]  = (state_q == ST_OFF && blinkSlot_q == SW'(i)) ? SEG_BLANK : segRaw;
    end

    assign score     = score_q;
    assign score_seg = score_digit(score_q);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hand_display.sv
// Directed bench for hand_display: loads, score latency, blink timing,
// blink restart, clear priority, out-of-range slot and async reset.
module tb_hand_display;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_ZERO  = 7'b1000000;
    localparam logic [6:0] S_ACE   = 7'b0001000;
    localparam logic [6:0] S_2     = 7'b0100100;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_6     = 7'b0000010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_8     = 7'b0000000;
    localparam logic [6:0] S_9     = 7'b0010000;
    localparam logic [6:0] S_KING  = 7'b0001001;

    logic        slowClock;
    logic        resetb;
    logic        clear;
    logic        loadEn;
    logic [1:0]  loadSlot;
    logic [3:0]  loadCard;
    logic        blinkEn;
    logic [11:0] cardsOut;
    logic [20:0] seg7Out;
    logic [3:0]  score;
    logic [6:0]  scoreSeg;
    logic        busy;

    int vectors;
    int miscompares;

    hand_display #(
        .NUM_SLOTS  (3),
        .BLINK_HALF (2),
        .BLINK_REPS (3)
    ) dut (
        .slow_clock (slowClock),
        .resetb     (resetb),
        .clear      (clear),
        .load_en    (loadEn),
        .load_slot  (loadSlot),
        .load_card  (loadCard),
        .blink_en   (blinkEn),
        .cards_out  (cardsOut),
        .seg7_out   (seg7Out),
        .score      (score),
        .score_seg  (scoreSeg),
        .busy       (busy)
    );

    initial slowClock = 1'b0;
    always #5 slowClock = ~slowClock;

    function automatic logic [6:0] slotSeg(input int i);
        return seg7Out[7*i +: 7];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 unit later.
    task automatic applyStimulus(input logic ld, input logic [1:0] slot, input logic [3:0] card,
                                 input logic blk, input logic clr);
        loadEn   = ld;
        loadSlot = slot;
        loadCard = card;
        blinkEn  = blk;
        clear    = clr;
        @(posedge slowClock);
        #1;
        loadEn  = 1'b0;
        blinkEn = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetb   = 1'b0;
        clear    = 1'b0;
        loadEn   = 1'b0;
        loadSlot = 2'd0;
        loadCard = 4'd0;
        blinkEn  = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(posedge slowClock);
        #1;
        checkOutput("rst_cards", 32'(cardsOut), 32'h000);
        checkOutput("rst_seg", 32'(seg7Out), 32'h1FFFFF);
        checkOutput("rst_score", 32'(score), 32'd0);
        checkOutput("rst_score_seg", 32'(scoreSeg), 32'(S_ZERO));
        checkOutput("rst_busy", 32'(busy), 32'd0);
        resetb = 1'b1;

        $display("[TB] load 7 and K");
        applyStimulus(1'b1, 2'd0, 4'd7, 1'b0, 1'b0);
        checkOutput("load7_cards", 32'(cardsOut), 32'h007);
        applyStimulus(1'b1, 2'd1, 4'd13, 1'b0, 1'b0);
        checkOutput("loadK_cards", 32'(cardsOut), 32'h0D7);
        checkOutput("seg_slot0_7", 32'(slotSeg(0)), 32'(S_7));
        checkOutput("seg_slot1_K", 32'(slotSeg(1)), 32'(S_KING));
        checkOutput("seg_slot2_empty", 32'(slotSeg(2)), 32'(S_BLANK));
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("score_7K", 32'(score), 32'd7);
        checkOutput("score_seg_7K", 32'(scoreSeg), 32'(S_7));

        $display("[TB] load 9 8 6, then 15");
        applyStimulus(1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 4'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 4'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("cards_986", 32'(cardsOut), 32'h689);
        checkOutput("score_986", 32'(score), 32'd3);
        checkOutput("score_seg_986", 32'(scoreSeg), 32'(S_3));
        checkOutput("seg_slot0_9", 32'(slotSeg(0)), 32'(S_9));
        checkOutput("seg_slot1_8", 32'(slotSeg(1)), 32'(S_8));
        checkOutput("seg_slot2_6", 32'(slotSeg(2)), 32'(S_6));
        applyStimulus(1'b1, 2'd2, 4'd15, 1'b0, 1'b0);
        checkOutput("cards_code15", 32'(cardsOut), 32'h089);
        checkOutput("score_lag", 32'(score), 32'd3);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("score_code15", 32'(score), 32'd7);
        checkOutput("seg_slot2_code15", 32'(slotSeg(2)), 32'(S_BLANK));

        $display("[TB] blink slot1");
        applyStimulus(1'b1, 2'd2, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 4'd4, 1'b1, 1'b0);
        checkOutput("blink_cards", 32'(cardsOut), 32'h249);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
            checkOutput($sformatf("blink_busy_c%0d", c), 32'(busy), 32'(c < 12));
            checkOutput($sformatf("blink_slot1_c%0d", c), 32'(slotSeg(1)),
                        32'((c < 12 && ((c / 2) % 2) == 0) ? S_BLANK : S_4));
            checkOutput($sformatf("blink_slot0_c%0d", c), 32'(slotSeg(0)), 32'(S_9));
            checkOutput($sformatf("blink_slot2_c%0d", c), 32'(slotSeg(2)), 32'(S_2));
            if (c == 1) checkOutput("blink_score", 32'(score), 32'd5);
        end

        $display("[TB] blink restart on slot2");
        applyStimulus(1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
        checkOutput("restart_pre_blank", 32'(slotSeg(1)), 32'(S_BLANK));
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 4'd7, 1'b1, 1'b0);
        for (int c = 0; c <= 12; c++) begin
            if (c == 5) applyStimulus(1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
            else if (c > 0) applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
            checkOutput($sformatf("restart_busy_c%0d", c), 32'(busy), 32'(c < 12));
            checkOutput($sformatf("restart_slot1_c%0d", c), 32'(slotSeg(1)), 32'(S_3));
            checkOutput($sformatf("restart_slot2_c%0d", c), 32'(slotSeg(2)),
                        32'((c < 12 && ((c / 2) % 2) == 0) ? S_BLANK : S_7));
            checkOutput($sformatf("restart_slot0_c%0d", c), 32'(slotSeg(0)),
                        32'((c >= 5) ? S_ACE : S_9));
        end
        checkOutput("restart_cards", 32'(cardsOut), 32'h731);

        $display("[TB] clear beats load");
        applyStimulus(1'b1, 2'd0, 4'd5, 1'b1, 1'b0);
        checkOutput("pre_clear_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 2'd1, 4'd9, 1'b1, 1'b1);
        checkOutput("clear_cards", 32'(cardsOut), 32'h000);
        checkOutput("clear_busy", 32'(busy), 32'd0);
        checkOutput("clear_seg", 32'(seg7Out), 32'h1FFFFF);
        checkOutput("clear_score_lag", 32'(score), 32'd5);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("clear_score", 32'(score), 32'd0);
        checkOutput("clear_score_seg", 32'(scoreSeg), 32'(S_ZERO));

        $display("[TB] out-of-range slot");
        applyStimulus(1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 4'd5, 1'b1, 1'b0);
        checkOutput("slot3_cards", 32'(cardsOut), 32'h002);
        checkOutput("slot3_busy", 32'(busy), 32'd0);
        checkOutput("slot3_seg0", 32'(slotSeg(0)), 32'(S_2));
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("slot3_score", 32'(score), 32'd2);

        $display("[TB] async reset mid-blink");
        applyStimulus(1'b1, 2'd1, 4'd6, 1'b1, 1'b0);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        checkOutput("arst_cards", 32'(cardsOut), 32'h000);
        checkOutput("arst_seg", 32'(seg7Out), 32'h1FFFFF);
        checkOutput("arst_score", 32'(score), 32'd0);
        checkOutput("arst_score_seg", 32'(scoreSeg), 32'(S_ZERO));
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(posedge slowClock);
        #1;
        resetb = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
